// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic-MAC streaming datapaths
// (input deserialiser and output serialiser).
package systolic_pkg;

    localparam int DATA_W = 64;
    localparam int CHUNKS = 8;
    localparam int OUT_W  = DATA_W * CHUNKS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        FULL    = 2'd2
    } rx_state_t;

endpackage : systolic_pkg

// File: rtl/input_datapath_rx_counter.sv
// Modulo-MODULUS chunk counter with sync reset, enable, a combinational
// terminal-count flag and a registered one-cycle done pulse.
module rx_counter #(
    parameter  int MODULUS = 8,
    localparam int CNT_W   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic             done
);

    assign tc = (count == CNT_W'(MODULUS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= en && tc;
            if (en) begin
                count <= tc ? '0 : count + CNT_W'(1);
            end
        end
    end

endmodule : rx_counter

// File: rtl/input_datapath.sv
// Deserialises DATA_W-bit chunks into one OUT_W-bit operand word for the
// systolic array feeder. Define INPUT_DATAPATH_MSB_FIRST_EN to place the
// first chunk at the MSBs instead of the LSBs.
module input_datapath
    import systolic_pkg::*;
#(
    parameter  int DATA_W = systolic_pkg::DATA_W,
    parameter  int CHUNKS = systolic_pkg::CHUNKS,
    localparam int OUT_W  = DATA_W * CHUNKS,
    localparam int CNT_W  = $clog2(CHUNKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              dest_ready,
    output logic [OUT_W-1:0]  systolic_input,
    output logic              in_valid,
    input  logic              systolic_ready,
    output logic [CNT_W-1:0]  rx_count,
    output logic              sh_count_done
);

    rx_state_t        state;
    rx_state_t        state_next;
    logic             transfer;
    logic             last_slot;
    logic [CNT_W-1:0] slot;
    logic [OUT_W-1:0] word;

    assign dest_ready = (state == RECEIVE);
    assign in_valid   = (state == FULL);
    assign transfer   = src_valid && dest_ready;

    rx_counter #(
        .MODULUS (CHUNKS)
    ) u_rx_counter (
        .clk   (clk),
        .reset (reset),
        .en    (transfer),
        .count (rx_count),
        .tc    (last_slot),
        .done  (sh_count_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next_state gets a default before the case so no path through
    // this block leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RECEIVE;
            RECEIVE: if (transfer && last_slot) state_next = FULL;
            FULL:    if (systolic_ready) state_next = RECEIVE;
            default: state_next = IDLE;
        endcase
    end

`ifdef INPUT_DATAPATH_MSB_FIRST_EN
    assign slot = CNT_W'(CHUNKS - 1) - rx_count;
`else
    assign slot = rx_count;
`endif

    // NOTE: the word register is reset because a discarded partial word
    // must never leak into the next one; otherwise slots are only overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (transfer) begin
            word[int'(slot) * DATA_W +: DATA_W] <= data_in;
        end
    end

    assign systolic_input = word;

endmodule : input_datapath

// File: tb/tb_input_datapath.sv
// Directed self-checking bench for input_datapath (8 x 64-bit chunks).
module tb_input_datapath;

    localparam int DW = 64;
    localparam int CH = 8;
    localparam int OW = DW * CH;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_valid;
    logic [DW-1:0] data_in;
    logic          dest_ready;
    logic [OW-1:0] systolic_input;
    logic          in_valid;
    logic          systolic_ready;
    logic [2:0]    rx_count;
    logic          sh_count_done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] wa [CH] = '{
        64'h1122334455667788, 64'h0FEDCBA987654321,
        64'h0123456789ABCDEF, 64'hA5A5A5A55A5A5A5A,
        64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF,
        64'h13579BDF2468ACE0, 64'hDEADBEEFCAFEBABE
    };
    logic [DW-1:0] wb [CH] = '{
        64'h0000000000000001, 64'h0000000000000002,
        64'h8000000000000000, 64'h4000000000000000,
        64'hC3C3C3C3C3C3C3C3, 64'h3C3C3C3C3C3C3C3C,
        64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0
    };

    logic [OW-1:0] full_word;
    logic [OW-1:0] exp_word;

    input_datapath dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .data_in        (data_in),
        .dest_ready     (dest_ready),
        .systolic_input (systolic_input),
        .in_valid       (in_valid),
        .systolic_ready (systolic_ready),
        .rx_count       (rx_count),
        .sh_count_done  (sh_count_done)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] put(input logic [OW-1:0] w, input int k,
                                          input logic [DW-1:0] c);
`ifdef INPUT_DATAPATH_MSB_FIRST_EN
        w[DW*(CH-1-k) +: DW] = c;
`else
        w[DW*k +: DW] = c;
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; src_valid = 1'b0; data_in = '0; systolic_ready = 1'b0;
        tick();
        tick();
        total++; if (dest_ready !== 1'b0) begin bad++; $display("FAIL rst_dest_ready got=%b exp=0", dest_ready); end
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL rst_in_valid got=%b exp=0", in_valid); end
        total++; if (systolic_input !== '0) begin bad++; $display("FAIL rst_word got=%h exp=0", systolic_input); end
        total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL rst_rx_count got=%0d exp=0", rx_count); end
        total++; if (sh_count_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", sh_count_done); end
        reset = 1'b0;
        total++; if (dest_ready !== 1'b0) begin bad++; $display("FAIL idle_dest_ready got=%b exp=0", dest_ready); end
        tick();
        total++; if (dest_ready !== 1'b1) begin bad++; $display("FAIL recv_dest_ready got=%b exp=1", dest_ready); end
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL recv_in_valid got=%b exp=0", in_valid); end
    endtask

    task automatic test_stream();
        exp_word = '0;
        for (int i = 0; i < CH; i++) begin
            src_valid = 1'b1;
            data_in   = wa[i];
            tick();
            exp_word = put(exp_word, i, wa[i]);
            total++; if (rx_count !== 3'(i + 1)) begin bad++; $display("FAIL stream_rx_count[%0d] got=%0d exp=%0d", i, rx_count, (i + 1) % CH); end
            total++; if (systolic_input !== exp_word) begin bad++; $display("FAIL stream_word[%0d] got=%h exp=%h", i, systolic_input, exp_word); end
            total++; if (in_valid !== logic'(i == CH - 1)) begin bad++; $display("FAIL stream_in_valid[%0d] got=%b exp=%b", i, in_valid, i == CH - 1); end
            total++; if (sh_count_done !== logic'(i == CH - 1)) begin bad++; $display("FAIL stream_done[%0d] got=%b exp=%b", i, sh_count_done, i == CH - 1); end
            total++; if (dest_ready !== logic'(i != CH - 1)) begin bad++; $display("FAIL stream_dest_ready[%0d] got=%b exp=%b", i, dest_ready, i != CH - 1); end
        end
        full_word = exp_word;
    endtask

    task automatic test_full_hold();
        src_valid = 1'b1; data_in = 64'hBAD0BAD0BAD0BAD0; systolic_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (dest_ready !== 1'b0) begin bad++; $display("FAIL hold_dest_ready[%0d] got=%b exp=0", i, dest_ready); end
            total++; if (in_valid !== 1'b1) begin bad++; $display("FAIL hold_in_valid[%0d] got=%b exp=1", i, in_valid); end
            total++; if (systolic_input !== full_word) begin bad++; $display("FAIL hold_word[%0d] got=%h exp=%h", i, systolic_input, full_word); end
            total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL hold_rx_count[%0d] got=%0d exp=0", i, rx_count); end
            total++; if (sh_count_done !== 1'b0) begin bad++; $display("FAIL hold_done[%0d] got=%b exp=0", i, sh_count_done); end
        end
    endtask

    task automatic test_consume();
        src_valid = 1'b0; systolic_ready = 1'b1;
        tick();
        systolic_ready = 1'b0;
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL consume_in_valid got=%b exp=0", in_valid); end
        total++; if (dest_ready !== 1'b1) begin bad++; $display("FAIL consume_dest_ready got=%b exp=1", dest_ready); end
        total++; if (systolic_input !== full_word) begin bad++; $display("FAIL consume_word got=%h exp=%h", systolic_input, full_word); end
        total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL consume_rx_count got=%0d exp=0", rx_count); end
    endtask

    task automatic test_gapped();
        int n      = 0;
        int pulses = 0;
        exp_word = full_word;
        for (int step = 0; step < 2 * CH; step++) begin
            src_valid = (step % 2 == 0);
            data_in   = src_valid ? wb[n] : 64'h5555AAAA5555AAAA;
            tick();
            if (src_valid) begin
                exp_word = put(exp_word, n, wb[n]);
                n++;
            end
            if (sh_count_done === 1'b1) pulses++;
            total++; if (rx_count !== 3'(n % CH)) begin bad++; $display("FAIL gap_rx_count[%0d] got=%0d exp=%0d", step, rx_count, n % CH); end
            total++; if (systolic_input !== exp_word) begin bad++; $display("FAIL gap_word[%0d] got=%h exp=%h", step, systolic_input, exp_word); end
        end
        src_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (sh_count_done === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL gap_done_pulses got=%0d exp=1", pulses); end
        total++; if (in_valid !== 1'b1) begin bad++; $display("FAIL gap_in_valid got=%b exp=1", in_valid); end
        full_word = exp_word;
        systolic_ready = 1'b1;
        tick();
        systolic_ready = 1'b0;
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL gap_consume got=%b exp=0", in_valid); end
    endtask

    task automatic test_ready_in_receive();
        exp_word = full_word;
        for (int i = 0; i < 2; i++) begin
            src_valid = 1'b1; data_in = wa[CH-1-i];
            tick();
            exp_word = put(exp_word, i, wa[CH-1-i]);
        end
        src_valid = 1'b0; systolic_ready = 1'b1;
        tick();
        systolic_ready = 1'b0;
        total++; if (rx_count !== 3'd2) begin bad++; $display("FAIL rdy_recv_rx_count got=%0d exp=2", rx_count); end
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL rdy_recv_in_valid got=%b exp=0", in_valid); end
        total++; if (dest_ready !== 1'b1) begin bad++; $display("FAIL rdy_recv_dest_ready got=%b exp=1", dest_ready); end
        total++; if (systolic_input !== exp_word) begin bad++; $display("FAIL rdy_recv_word got=%h exp=%h", systolic_input, exp_word); end
    endtask

    task automatic test_reset_mid_word();
        src_valid = 1'b1; data_in = wa[5];
        tick();
        total++; if (rx_count !== 3'd3) begin bad++; $display("FAIL mid_rx_count got=%0d exp=3", rx_count); end
        reset = 1'b1; data_in = 64'h7777777777777777;
        tick();
        total++; if (dest_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_dest_ready got=%b exp=0", dest_ready); end
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_in_valid got=%b exp=0", in_valid); end
        total++; if (systolic_input !== '0) begin bad++; $display("FAIL mid_rst_word got=%h exp=0", systolic_input); end
        total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL mid_rst_rx_count got=%0d exp=0", rx_count); end
        total++; if (sh_count_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b exp=0", sh_count_done); end
        reset = 1'b0;
        tick();
        total++; if (rx_count !== 3'd0 || systolic_input !== '0) begin bad++; $display("FAIL idle_no_capture rx=%0d word=%h exp rx=0 word=0", rx_count, systolic_input); end
        exp_word = '0;
        for (int i = 0; i < CH; i++) begin
            src_valid = 1'b1; data_in = wb[CH-1-i];
            tick();
            exp_word = put(exp_word, i, wb[CH-1-i]);
            total++; if (systolic_input !== exp_word) begin bad++; $display("FAIL fresh_word[%0d] got=%h exp=%h", i, systolic_input, exp_word); end
        end
        src_valid = 1'b0;
        total++; if (in_valid !== 1'b1) begin bad++; $display("FAIL fresh_in_valid got=%b exp=1", in_valid); end
        total++; if (sh_count_done !== 1'b1) begin bad++; $display("FAIL fresh_done got=%b exp=1", sh_count_done); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_hold();
        test_consume();
        test_gapped();
        test_ready_in_receive();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_datapath
